// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: prescaled pixel clock, h/v counters, sync/active decode, line/frame strobes.
// Latency: all outputs are registered on the pixel-advance edge and describe the same pixel (zero skew).
// Backpressure: none; enable low freezes every counter and output, and forces the strobes to 0.
//
// Ports:
//   clk          single clock
//   reset        asynchronous, active-low reset
//   enable       run when high, freeze when low
//   pix_tick     one-clk strobe on each pixel advance
//   hsync/vsync  sync outputs, asserted level HS_POL/VS_POL
//   active       current pixel lies in the visible region
//   x/y          current horizontal/vertical count (valid during blanking too)
//   line_start   one-clk strobe when x becomes 0
//   frame_start  one-clk strobe when x and y both become 0
module vga_sync_gen #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned XW       = 10,
  parameter int unsigned YW       = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  output logic          pix_tick,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [PW-1:0] PS_LAST = PW'(CLK_DIV - 1);
  localparam logic [XW-1:0] H_LAST  = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_LAST  = YW'(V_TOTAL - 1);

  // Region bounds kept at 32 bits so an end bound equal to 2^XW does not truncate to 0.
  localparam logic [31:0] HS_START = H_ACTIVE + H_FP;
  localparam logic [31:0] HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam logic [31:0] VS_START = V_ACTIVE + V_FP;
  localparam logic [31:0] VS_END   = V_ACTIVE + V_FP + V_SYNC;

  if (H_SYNC == 0 || V_SYNC == 0) begin : g_bad_sync
    $error("vga_sync_gen: H_SYNC and V_SYNC must be non-zero");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_sync_gen: CLK_DIV must be in 1..16");
  end

  logic [PW-1:0] ps_q, ps_d;
  logic [XW-1:0] h_q, h_d;
  logic [YW-1:0] v_q, v_d;
  logic          hsync_q, vsync_q, active_q;
  logic          tick_q, ls_q, fs_q;
  logic          ps_wrap;

  // Next-state counters. h/v only move on the enabled cycle where the prescaler wraps.
  always_comb begin
    ps_wrap = enable && (ps_q == PS_LAST);
    ps_d    = ps_q;
    h_d     = h_q;
    v_d     = v_q;
    if (enable) begin
      if (ps_wrap) begin
        ps_d = '0;
        if (h_q == H_LAST) begin
          h_d = '0;
          v_d = (v_q == V_LAST) ? '0 : v_q + YW'(1);
        end else begin
          h_d = h_q + XW'(1);
        end
      end else begin
        ps_d = ps_q + PW'(1);
      end
    end
  end

  // Decode the pixel about to be presented, so outputs register together with h/v.
  logic [31:0] h_nx, v_nx;
  logic        hsync_d, vsync_d, active_d;
  assign h_nx     = 32'(h_d);
  assign v_nx     = 32'(v_d);
  assign hsync_d  = (h_nx >= HS_START && h_nx < HS_END) ? HS_POL : ~HS_POL;
  assign vsync_d  = (v_nx >= VS_START && v_nx < VS_END) ? VS_POL : ~VS_POL;
  assign active_d = (h_nx < H_ACTIVE) && (v_nx < V_ACTIVE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps_q     <= '0;
      h_q      <= '0;
      v_q      <= '0;
      hsync_q  <= ~HS_POL;
      vsync_q  <= ~VS_POL;
      active_q <= 1'b1;
      tick_q   <= 1'b0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
      if (enable) begin
        ps_q <= ps_d;
        if (ps_wrap) begin
          h_q      <= h_d;
          v_q      <= v_d;
          hsync_q  <= hsync_d;
          vsync_q  <= vsync_d;
          active_q <= active_d;
          tick_q   <= 1'b1;
          ls_q     <= (h_d == '0);
          fs_q     <= (h_d == '0) && (v_d == '0);
        end
      end
    end
  end

  // Strobes are gated so they read 0 in any cycle where enable is low, even
  // the one immediately following a pixel advance.
  assign pix_tick    = tick_q & enable;
  assign line_start  = ls_q & enable;
  assign frame_start = fs_q & enable;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign x           = h_q;
  assign y           = v_q;

endmodule
